// File: rtl/guess_checker_if.sv
// Bundle between the letter-guess game logic and its surroundings: the target word and
// key inputs going in, the display drive and game status coming out.
interface guess_checker_if;
  logic [24:0] target_word;
  logic [4:0]  letter_in;
  logic        guess_key;
  logic        new_game;
  logic [4:0]  location_matches;
  logic [4:0]  current_letter;
  logic [4:0]  display_reset;
  logic [2:0]  wrong_count;
  logic        game_won;
  logic        game_lost;
  logic        busy;

  modport master (
    output target_word, letter_in, guess_key, new_game,
    input  location_matches, current_letter, display_reset, wrong_count,
           game_won, game_lost, busy
  );

  modport slave (
    input  target_word, letter_in, guess_key, new_game,
    output location_matches, current_letter, display_reset, wrong_count,
           game_won, game_lost, busy
  );
endinterface

// File: rtl/guess_checker.sv
// Serial 5-letter guess checker: compares one guess per key edge against a latched word,
// keeps a sticky found mask, and holds display-facing outputs steady while boxes are drawn.
module guess_checker #(
  parameter int MAX_WRONG    = 6,
  parameter int CLEAR_CYCLES = 16,
  parameter int HOLD_CYCLES  = 1024
) (
  input logic           clk,
  input logic           rst,
  guess_checker_if.slave gc
);

  localparam int CNT_MAX = (CLEAR_CYCLES > HOLD_CYCLES) ? CLEAR_CYCLES : HOLD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    CLEAR, IDLE, COMPARE, UPDATE, HOLD, WIN, LOSE
  } state_t;

  state_t        state;
  logic [4:0]    word [5];
  logic [4:0]    found;
  logic [4:0]    new_mask;
  logic [4:0]    cur;
  logic          hit;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic          key_prev;
  logic [4:0]    disp;
  logic [2:0]    wrong;
  logic          won;
  logic          lost;
  logic          busy_q;

  logic          key_edge;
  logic [4:0]    merged;
  logic [2:0]    wrong_inc;

  assign key_edge  = gc.guess_key & ~key_prev;
  assign merged    = found | new_mask;
  assign wrong_inc = (wrong == 3'(MAX_WRONG)) ? wrong : wrong + 3'd1;

  always_ff @(posedge clk) begin
    // new_game shares the reset path; while held it keeps CLEAR's counter at zero
    if (rst || gc.new_game) begin
      for (int i = 0; i < 5; i++) begin
        word[i] <= gc.target_word[5*i +: 5];
      end
      found    <= '0;
      new_mask <= '0;
      cur      <= '0;
      hit      <= 1'b0;
      idx      <= '0;
      wrong    <= '0;
      won      <= 1'b0;
      lost     <= 1'b0;
      disp     <= 5'b00000;
      key_prev <= 1'b1;
      cnt      <= '0;
      busy_q   <= 1'b1;
      state    <= CLEAR;
    end else begin
      key_prev <= gc.guess_key;
      case (state)
        CLEAR: begin
          if (cnt == CW'(CLEAR_CYCLES - 1)) begin
            cnt    <= '0;
            disp   <= 5'b11111;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IDLE: begin
          if (key_edge && gc.letter_in <= 5'd25) begin
            cur      <= gc.letter_in;
            hit      <= 1'b0;
            new_mask <= '0;
            idx      <= '0;
            busy_q   <= 1'b1;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          // A repeat of an already-found letter still counts as a hit, so it costs nothing
          if (word[idx] == cur) begin
            hit           <= 1'b1;
            new_mask[idx] <= ~found[idx];
          end
          if (idx == 3'd4) begin
            state <= UPDATE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        UPDATE: begin
          found <= merged;
          if (!hit) begin
            wrong <= wrong_inc;
          end
          if (merged == 5'b11111) begin
            won   <= 1'b1;
            state <= WIN;
          end else if (!hit && wrong_inc == 3'(MAX_WRONG)) begin
            lost  <= 1'b1;
            state <= LOSE;
          end else begin
            cnt   <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign gc.location_matches = found;
  assign gc.current_letter   = cur;
  assign gc.display_reset    = disp;
  assign gc.wrong_count      = wrong;
  assign gc.game_won         = won;
  assign gc.game_lost        = lost;
  assign gc.busy             = busy_q;

endmodule

// File: doc/guess_checker.md
Name: guess_checker

Overview:
- Game-logic stage that sits directly upstream of the VGA letter display.
- Accepts one letter guess per key press and compares it serially against a latched 5-letter target word.
- Drives the display's inputs: sticky per-position match mask, the letter to draw, and the active-low per-box clear vector.
- Tracks wrong guesses and signals win/lose; holds its outputs stable long enough for the display to finish drawing.

Parameters:
- MAX_WRONG, 6, number of wrong guesses that ends the game (1..7).
- CLEAR_CYCLES, 16, cycles display_reset is held at 5'b00000 after reset or new_game.
- HOLD_CYCLES, 1024, cycles guesses are ignored after an accepted guess (covers worst-case box draw).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- target_word  in  25  letter i at bits [5i+4:5i]; position 0 = leftmost box; latched on reset and new_game
- letter_in  in  5  guess letter, 0=A..25=Z; 26..31 invalid
- guess_key  in  1  level, already synchronised; a rising edge submits letter_in
- new_game  in  1  level; sampled high = restart
- location_matches  out  5  sticky found mask, bit i = position i revealed
- current_letter  out  5  letter the display draws in newly set boxes
- display_reset  out  5  active-low per-box clear to display (0 = clear box)
- wrong_count  out  3  wrong guesses so far, saturates at MAX_WRONG
- game_won  out  1  all 5 positions found
- game_lost  out  1  wrong_count reached MAX_WRONG
- busy  out  1  high in every state except IDLE

Behaviour:
- States: CLEAR, IDLE, COMPARE, UPDATE, HOLD, WIN, LOSE.
- Reset (rst=1 at a clock edge):
  - word register <= target_word; found mask, current_letter, wrong_count, game_won, game_lost <= 0.
  - display_reset <= 5'b00000; internal key_prev <= 1; state <= CLEAR with clear counter 0.
- CLEAR:
  - display_reset = 5'b00000; counter increments each cycle.
  - After CLEAR_CYCLES cycles: display_reset <= 5'b11111, state <= IDLE.
  - Any guess edge seen during CLEAR is discarded.
- Edge detect: key_prev registers guess_key every cycle in all states. Edge = guess_key & ~key_prev.
- IDLE, edge at cycle k:
  - letter_in <= 25: current_letter <= letter_in (visible k+1); clear hit and new_mask scratch; idx <= 0; state <= COMPARE.
  - letter_in >= 26: ignored, no state or output change.
- COMPARE (cycles k+1..k+5), at idx:
  - if word[idx] == current_letter: hit <= 1 and new_mask[idx] <= ~found[idx].
  - idx increments; after idx=4, state <= UPDATE.
- UPDATE (cycle k+6); results visible from k+7:
  - found <= found | new_mask.
  - if hit == 0, wrong_count <= wrong_count+1 (saturating).
  - Letter present but all its positions already found: no penalty, no change.
  - Next state, in priority order: all found -> WIN (game_won=1); wrong_count reaches MAX_WRONG -> LOSE (game_lost=1); else HOLD.
- HOLD:
  - Counts HOLD_CYCLES, then IDLE.
  - Edges during HOLD are dropped, not queued.
  - location_matches and current_letter stay stable throughout.
- WIN / LOSE: absorbing; all guesses ignored; outputs frozen until new_game or rst.
- new_game:
  - Sampled high in any state other than CLEAR: same actions as reset.
  - Aborts COMPARE/UPDATE/HOLD with no partial update to found or wrong_count.
  - Has priority over a simultaneous guess edge.
  - Held high: remains in CLEAR with the counter restarting; exits CLEAR_CYCLES cycles after it drops.
- rst has priority over everything.
- location_matches = found. game_won and game_lost are never both 1.

Test Plan:
- Word "CRANE" (C=2,R=17,A=0,N=13,E=4), rst then wait: display_reset=00000 for 16 cycles, then 11111; busy=0; all other outputs 0.
- Guess A (0): current_letter=0 at k+1; location_matches=00100 at k+7; wrong_count=0; busy high until HOLD ends (1024 cycles), then 0.
- Word "LEVEL", guess L (11): location_matches=10001 in a single update; repeat L after HOLD: mask unchanged, wrong_count unchanged.
- Guess Z (25) six times, spaced past HOLD: wrong_count 1..6; game_lost=1 after the sixth; a further guess of C leaves all outputs unchanged.
- Guesses C,R,A,N,E: game_won=1 and mask=11111 after E. Then new_game pulse: display_reset=00000 for 16 cycles; mask=0; game_won=0.
- Edge-case stimulus:
  - Guess edge during HOLD -> ignored.
  - letter_in=30 -> ignored.
  - new_game asserted at COMPARE idx=2 -> no mask or count change; state CLEAR.
  - rst together with new_game -> identical to reset.
